ram_arbiter: RTL and testbench

- Sequencer/arbiter that shares the 16x4 single-port RAM between two requesters, A and B.
- After reset, clears every RAM location to INIT_VAL. It then grants one access per cycle with round-robin fairness.
- Sits between the requesters and the RAM. It drives the RAM clock-enable/address/write-data lines and samples the combinational RAM read data.

---
 rtl/ram_arbiter_pkg.sv | 8 +
 rtl/ram_arbiter_rr_arb2.sv | 15 +
 rtl/ram_arbiter.sv | 89 ++++++++
 tb/tb_ram_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths, sequencer state and round-robin pointer encodings.
package ram_arbiter_pkg;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 4;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ptr names the side that wins a tie.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       next_ptr_o
);
  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | (ptr_i == PTR_A));
    gnt_o[1] = req_i[1] & (~req_i[0] | (ptr_i == PTR_B));
    next_ptr_o = gnt_o[0] ? PTR_B : gnt_o[1] ? PTR_A : ptr_i;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: clears the shared RAM after reset, then grants A/B one access per cycle round-robin.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_en,
  output logic [AW-1:0] ram_ab,
  output logic [DW-1:0] ram_dbi,
  input  logic [DW-1:0] ram_dbo,
  output logic          init_done
);
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, ab_q;
  logic          ptr_q, ptr_d;
  logic [1:0]    gnt;
  logic          a_rvalid_q, b_rvalid_q, init_done_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          run;

  assign run = (state_q == ST_RUN);

  rr_arb2 u_arb (
    .req_i      ({b_req & run, a_req & run}),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .next_ptr_o (ptr_d)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;

  always_comb
    state_d = (state_q == ST_INIT && &cnt_q) ? ST_RUN : state_q;

  // ram_en is gated by rst_n so an asserted reset aborts any write in flight
  always_comb begin
    a_gnt     = gnt[0];
    b_gnt     = gnt[1];
    ram_ab    = !run ? cnt_q : gnt[0] ? a_addr : gnt[1] ? b_addr : ab_q;
    ram_dbi   = !run ? INIT_VAL : gnt[1] ? b_wdata : a_wdata;
    ram_en    = rst_n & (!run | (gnt[0] & a_we) | (gnt[1] & b_we));
    a_rvalid  = a_rvalid_q;
    b_rvalid  = b_rvalid_q;
    a_rdata   = a_rdata_q;
    b_rdata   = b_rdata_q;
    init_done = init_done_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q       <= '0;
      ab_q        <= '0;
      ptr_q       <= PTR_A;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      cnt_q       <= run ? cnt_q : cnt_q + 1'b1;
      ab_q        <= ram_ab;
      ptr_q       <= ptr_d;
      a_rvalid_q  <= gnt[0] & ~a_we;
      b_rvalid_q  <= gnt[1] & ~b_we;
      init_done_q <= (state_d == ST_RUN);
      if (gnt[0] & ~a_we) a_rdata_q <= ram_dbo;
      if (gnt[1] & ~b_we) b_rdata_q <= ram_dbo;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of init sweep, arbitration, read return and reset abort.
module tb_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [3:0] a_rdata, b_rdata;
  logic       ram_en, init_done;
  logic [3:0] ram_ab, ram_dbi, ram_dbo;
  logic [3:0] mem [16];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) mem[ram_ab] <= ram_dbi;
  assign ram_dbo = mem[ram_ab];

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_ab(ram_ab), .ram_dbi(ram_dbi), .ram_dbo(ram_dbo),
    .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic ar, input logic aw, input logic [3:0] aa, input logic [3:0] ad,
                     input logic br, input logic bw, input logic [3:0] ba, input logic [3:0] bd,
                     input logic eag, input logic ebg, input string tag);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    chk({tag, "_gnt"}, {a_gnt, b_gnt}, {eag, ebg});
    tick;
  endtask

  task automatic rv(input logic eav, input logic [3:0] ead, input logic ebv, input logic [3:0] ebd,
                    input string tag);
    chk({tag, "_a_rvalid"}, a_rvalid, eav);
    chk({tag, "_a_rdata"}, a_rdata, ead);
    chk({tag, "_b_rvalid"}, b_rvalid, ebv);
    chk({tag, "_b_rdata"}, b_rdata, ebd);
  endtask

  task automatic sweep(input bit late_req);
    for (int i = 0; i < 16; i++) begin
      if (late_req && i == 2) begin
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5; a_wdata = 4'h0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_wdata = 4'h6;
      end
      #1;
      chk("init_en", ram_en, 1);
      chk("init_ab", ram_ab, 8'(i));
      chk("init_dbi", ram_dbi, 0);
      chk("init_gnt", {a_gnt, b_gnt}, 0);
      chk("init_done_lo", init_done, 0);
      tick;
    end
    chk("init_done_hi", init_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    #2;
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_done", init_done, 0);
    rv(0, 0, 0, 0, "rst");
    tick;
    rst_n = 1'b1;
    sweep(0);
    acc(1, 0, 4'd0, 0, 0, 0, 0, 0, 1, 0, "rd0");
    rv(1, 4'h0, 0, 0, "rd0");
    acc(1, 0, 4'd7, 0, 0, 0, 0, 0, 1, 0, "rd7");
    rv(1, 4'h0, 0, 0, "rd7");
    acc(1, 0, 4'd15, 0, 0, 0, 0, 0, 1, 0, "rd15");
    rv(1, 4'h0, 0, 0, "rd15");
    acc(1, 1, 4'd3, 4'hA, 0, 0, 0, 0, 1, 0, "wr3");
    rv(0, 4'h0, 0, 0, "wr3");
    acc(1, 0, 4'd3, 0, 0, 0, 0, 0, 1, 0, "rd3");
    rv(1, 4'hA, 0, 0, "rd3");
    acc(1, 1, 4'd1, 4'hC, 0, 0, 0, 0, 1, 0, "wr1");
    rv(0, 4'hA, 0, 0, "wr1");
    acc(0, 0, 0, 0, 1, 1, 4'd2, 4'h9, 0, 1, "wr2");
    rv(0, 4'hA, 0, 0, "wr2");
    for (int k = 0; k < 6; k++) begin
      acc(1, 0, 4'd1, 0, 1, 0, 4'd2, 0, k % 2 == 0, k % 2 == 1, "cont");
      rv(k % 2 == 0, 4'hC, k % 2 == 1, k == 0 ? 4'h0 : 4'h9, "cont");
    end
    for (int j = 0; j < 5; j++) begin
      a_req = 0; b_req = 0;
      #1;
      chk("idle_gnt", {a_gnt, b_gnt}, 0);
      chk("idle_en", ram_en, 0);
      chk("idle_ab", ram_ab, 4'd2);
      tick;
      rv(0, 4'hC, 0, 4'h9, "idle");
    end
    a_req = 1; a_we = 1; a_addr = 4'd9; a_wdata = 4'hF;
    b_req = 1; b_we = 0; b_addr = 4'd0; b_wdata = 0;
    #1;
    chk("ptr_gnt", {a_gnt, b_gnt}, 2'b10);
    chk("wr9_en", ram_en, 1);
    chk("wr9_ab", ram_ab, 4'd9);
    rst_n = 1'b0;
    #1;
    chk("abort_gnt", {a_gnt, b_gnt}, 0);
    chk("abort_en", ram_en, 0);
    chk("abort_done", init_done, 0);
    rv(0, 0, 0, 0, "abort");
    a_req = 0; b_req = 0;
    tick;
    rst_n = 1'b1;
    sweep(1);
    acc(1, 0, 4'd5, 0, 1, 1, 4'd5, 4'h6, 1, 0, "initA");
    rv(1, 4'h0, 0, 0, "initA");
    acc(0, 0, 0, 0, 1, 1, 4'd5, 4'h6, 0, 1, "initB");
    rv(0, 4'h0, 0, 0, "initB");
    acc(1, 0, 4'd5, 0, 0, 0, 0, 0, 1, 0, "rd5");
    rv(1, 4'h6, 0, 0, "rd5");
    acc(1, 0, 4'd9, 0, 0, 0, 0, 0, 1, 0, "rd9");
    rv(1, 4'h0, 0, 0, "rd9");
    a_req = 0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
